// File: rtl/sargantana_icache_refill_buf.sv
// I-cache refill buffer: issues one L2 line request per miss, assembles 4 beats into a line.
// Latency: miss accept -> L2 request 1 cycle; critical chunk forwarded combinationally on its beat; line fill 1 cycle after final beat.
// Backpressure: miss_ready_o only in IDLE; L2 request held until l2_req_ready_i; response beats are never stalled.
module sargantana_icache_refill_buf #(
  parameter int PADDR_W = 40,
  parameter int BEAT_W  = 128,
  parameter int LINE_W  = 512
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               miss_valid_i,
  input  logic [PADDR_W-1:0] miss_paddr_i,
  input  logic [1:0]         miss_idx_i,
  output logic               miss_ready_o,
  output logic               l2_req_valid_o,
  output logic [PADDR_W-1:0] l2_req_addr_o,
  input  logic               l2_req_ready_i,
  input  logic               l2_rsp_valid_i,
  input  logic [BEAT_W-1:0]  l2_rsp_data_i,
  input  logic               l2_rsp_err_i,
  output logic               fwd_valid_o,
  output logic [BEAT_W-1:0]  fwd_data_o,
  output logic               ifill_valid_o,
  output logic [LINE_W-1:0]  ifill_data_o,
  output logic [PADDR_W-1:0] ifill_addr_o,
  output logic               ifill_err_o
);

  localparam int N_BEATS = LINE_W / BEAT_W;
  localparam int OFF_W   = $clog2(LINE_W / 8);
  localparam logic [1:0] LAST_BEAT = 2'(N_BEATS - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    FILL = 3'd2,
    DONE = 3'd3,
    KILL = 3'd4
  } state_t;

  state_t                           state_q, state_d;
  logic [PADDR_W-1:0]               addr_q, addr_d;
  logic [1:0]                       idx_q, idx_d;
  logic [1:0]                       cnt_q, cnt_d;
  logic                             err_q, err_d;
  logic [N_BEATS-1:0][BEAT_W-1:0]   line_q, line_d;
  logic                             last_beat;

  assign last_beat     = (cnt_q == LAST_BEAT);
  assign l2_req_addr_o = addr_q;
  assign ifill_addr_o  = addr_q;
  assign ifill_data_o  = line_q;
  assign fwd_data_o    = l2_rsp_data_i;
  assign ifill_err_o   = ifill_valid_o & err_q;

  // Control state and refill bookkeeping; reset abandons any refill in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Line buffer data needs no reset; it is only observed alongside ifill_valid_o.
  always_ff @(posedge clk_i) begin
    line_q <= line_d;
  end

  // Next-state and output decode; a flush that races the L2 handshake still drains the accepted line.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    idx_d          = idx_q;
    cnt_d          = cnt_q;
    err_d          = err_q;
    line_d         = line_q;
    miss_ready_o   = 1'b0;
    l2_req_valid_o = 1'b0;
    fwd_valid_o    = 1'b0;
    ifill_valid_o  = 1'b0;
    case (state_q)
      IDLE: begin
        miss_ready_o = 1'b1;
        if (miss_valid_i) begin
          addr_d  = {miss_paddr_i[PADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          idx_d   = miss_idx_i;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        l2_req_valid_o = 1'b1;
        if (l2_req_ready_i) begin
          state_d = flush_i ? KILL : FILL;
        end else if (flush_i) begin
          state_d = IDLE;
        end
      end
      FILL: begin
        if (l2_rsp_valid_i) begin
          line_d[cnt_q] = l2_rsp_data_i;
          err_d         = err_q | l2_rsp_err_i;
          cnt_d         = cnt_q + 2'd1;
          fwd_valid_o   = (cnt_q == idx_q) & ~flush_i;
          if (flush_i) begin
            state_d = last_beat ? IDLE : KILL;
          end else if (last_beat) begin
            state_d = DONE;
          end
        end else if (flush_i) begin
          state_d = KILL;
        end
      end
      KILL: begin
        if (l2_rsp_valid_i) begin
          cnt_d = cnt_q + 2'd1;
          if (last_beat) begin
            state_d = IDLE;
          end
        end
      end
      DONE: begin
        ifill_valid_o = ~flush_i;
        state_d       = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sargantana_icache_refill_buf.sv
module tb_sargantana_icache_refill_buf;

  localparam int PADDR_W = 40;
  localparam int BEAT_W  = 128;
  localparam int LINE_W  = 512;

  logic               clk = 1'b0;
  logic               rst_i, flush_i, miss_valid_i, l2_req_ready_i, l2_rsp_valid_i, l2_rsp_err_i;
  logic [PADDR_W-1:0] miss_paddr_i;
  logic [1:0]         miss_idx_i;
  logic [BEAT_W-1:0]  l2_rsp_data_i;
  logic               miss_ready_o, l2_req_valid_o, fwd_valid_o, ifill_valid_o, ifill_err_o;
  logic [PADDR_W-1:0] l2_req_addr_o, ifill_addr_o;
  logic [BEAT_W-1:0]  fwd_data_o;
  logic [LINE_W-1:0]  ifill_data_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sargantana_icache_refill_buf #(.PADDR_W(PADDR_W), .BEAT_W(BEAT_W), .LINE_W(LINE_W)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .miss_valid_i(miss_valid_i), .miss_paddr_i(miss_paddr_i), .miss_idx_i(miss_idx_i),
    .miss_ready_o(miss_ready_o),
    .l2_req_valid_o(l2_req_valid_o), .l2_req_addr_o(l2_req_addr_o), .l2_req_ready_i(l2_req_ready_i),
    .l2_rsp_valid_i(l2_rsp_valid_i), .l2_rsp_data_i(l2_rsp_data_i), .l2_rsp_err_i(l2_rsp_err_i),
    .fwd_valid_o(fwd_valid_o), .fwd_data_o(fwd_data_o),
    .ifill_valid_o(ifill_valid_o), .ifill_data_o(ifill_data_o),
    .ifill_addr_o(ifill_addr_o), .ifill_err_o(ifill_err_o)
  );

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BEAT_W-1:0] rnd_beat();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_miss_rdy"}, miss_ready_o, 1);
    chk({tag, "_req_vld"}, l2_req_valid_o, 0);
    chk({tag, "_fwd_vld"}, fwd_valid_o, 0);
    chk({tag, "_ifill_vld"}, ifill_valid_o, 0);
    chk({tag, "_ifill_err"}, ifill_err_o, 0);
  endtask

  // One miss transaction. mode: 0 normal, 1 flush in REQ, 2 flush after beat fl,
  // 3 flush coincident with line delivery, 4 reset after beat fl.
  task automatic do_miss(input logic [PADDR_W-1:0] a, input logic [1:0] idx, input int rdy_dly,
                         input logic [3:0] errs, input int mode, input int fl, input int gapmax);
    logic [3:0][BEAT_W-1:0] beats;
    logic [PADDR_W-1:0]     aa;
    logic                   killed;
    logic                   flush_now;
    logic                   exp_fwd;
    int                     gaps;
    for (int k = 0; k < 4; k++) beats[k] = rnd_beat();
    aa = {a[PADDR_W-1:6], 6'b0};

    // A stray response beat while idle must be ignored.
    l2_rsp_valid_i = 1'b1;
    l2_rsp_data_i  = rnd_beat();
    #1;
    chk("idle_fwd", fwd_valid_o, 0);
    chk("idle_miss_rdy", miss_ready_o, 1);
    tick();
    l2_rsp_valid_i = 1'b0;

    miss_valid_i = 1'b1;
    miss_paddr_i = a | PADDR_W'($urandom_range(0, 63));
    miss_idx_i   = idx;
    #1;
    chk("accept_rdy", miss_ready_o, 1);
    tick();
    miss_valid_i = 1'b0;
    miss_paddr_i = '0;
    miss_idx_i   = 2'($urandom_range(0, 3));

    for (int d = 0; d <= rdy_dly; d++) begin
      if (mode == 1) begin
        flush_i = 1'b1;
        l2_req_ready_i = 1'b0;
        #1;
        chk("req_vld_flush", l2_req_valid_o, 1);
        tick();
        flush_i = 1'b0;
        #1;
        chk("req_flush_idle_rdy", miss_ready_o, 1);
        chk("req_flush_dropped", l2_req_valid_o, 0);
        return;
      end
      l2_req_ready_i = (d == rdy_dly);
      l2_rsp_valid_i = 1'($urandom_range(0, 1));
      l2_rsp_data_i  = rnd_beat();
      #1;
      chk("req_vld", l2_req_valid_o, 1);
      chk("req_addr", l2_req_addr_o, aa);
      chk("req_miss_rdy", miss_ready_o, 0);
      tick();
    end
    l2_req_ready_i = 1'b0;
    l2_rsp_valid_i = 1'b0;

    killed = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (mode == 2 && fl < 2 && b == fl + 1) begin
        flush_i = 1'b1;
        #1;
        chk("flush_gap_fwd", fwd_valid_o, 0);
        tick();
        flush_i = 1'b0;
        killed = 1'b1;
      end
      gaps = $urandom_range(0, gapmax);
      repeat (gaps) begin
        #1;
        chk("gap_fwd", fwd_valid_o, 0);
        chk("gap_miss_rdy", miss_ready_o, 0);
        chk("gap_ifill", ifill_valid_o, 0);
        tick();
      end
      if (mode == 4 && b == fl + 1) begin
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        chk_reset_outputs("rst_fill");
        return;
      end
      flush_now      = (mode == 2 && fl == 2 && b == 3);
      flush_i        = flush_now;
      l2_rsp_valid_i = 1'b1;
      l2_rsp_data_i  = beats[b];
      l2_rsp_err_i   = errs[b];
      #1;
      exp_fwd = !killed && !flush_now && (b == int'(idx));
      chk("beat_fwd_vld", fwd_valid_o, exp_fwd);
      if (exp_fwd) chk("beat_fwd_dat", fwd_data_o, beats[b]);
      chk("beat_ifill", ifill_valid_o, 0);
      chk("beat_miss_rdy", miss_ready_o, 0);
      tick();
      flush_i        = 1'b0;
      l2_rsp_valid_i = 1'b0;
      l2_rsp_err_i   = 1'b0;
    end

    if (mode == 2) begin
      #1;
      chk("kill_done_rdy", miss_ready_o, 1);
      chk("kill_no_ifill", ifill_valid_o, 0);
      return;
    end

    flush_i = (mode == 3);
    #1;
    chk("done_ifill_vld", ifill_valid_o, mode != 3);
    chk("done_ifill_err", ifill_err_o, (mode != 3) && (errs != 4'b0));
    chk("done_miss_rdy", miss_ready_o, 0);
    if (mode != 3) begin
      chk("done_ifill_dat", ifill_data_o, {beats[3], beats[2], beats[1], beats[0]});
      chk("done_ifill_addr", ifill_addr_o, aa);
    end
    tick();
    flush_i = 1'b0;
    #1;
    chk("post_done_rdy", miss_ready_o, 1);
    chk("post_done_ifill", ifill_valid_o, 0);
  endtask

  initial begin
    int mode;
    logic [3:0] errs;
    rst_i = 1'b1; flush_i = 1'b0; miss_valid_i = 1'b0; miss_paddr_i = '0; miss_idx_i = '0;
    l2_req_ready_i = 1'b0; l2_rsp_valid_i = 1'b0; l2_rsp_data_i = '0; l2_rsp_err_i = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("in_reset");
    rst_i = 1'b0;
    #1;
    chk_reset_outputs("after_reset");

    do_miss(40'h1000, 2'd2, 0, 4'b0000, 0, 0, 0);
    do_miss(40'h23_4567_8840, 2'd1, 5, 4'b0000, 0, 0, 1);
    do_miss(40'h00_0000_2fc0, 2'd3, 1, 4'b0010, 0, 0, 1);
    do_miss(40'h00_0000_3000, 2'd0, 0, 4'b0000, 2, 0, 0);
    do_miss(40'h00_0000_3040, 2'd0, 0, 4'b0000, 0, 0, 0);
    do_miss(40'h00_0000_4000, 2'd1, 0, 4'b1000, 3, 0, 0);
    do_miss(40'h00_0000_5000, 2'd2, 2, 4'b0000, 2, 2, 1);
    do_miss(40'h00_0000_6000, 2'd3, 0, 4'b0000, 4, 1, 1);
    do_miss(40'h00_0000_6040, 2'd3, 0, 4'b0000, 0, 0, 1);
    do_miss(40'h00_0000_7000, 2'd0, 3, 4'b0000, 1, 0, 0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 7))
        0, 1, 2: mode = 0;
        3:       mode = 1;
        4:       mode = 2;
        5:       mode = 3;
        6:       mode = 4;
        default: mode = 0;
      endcase
      errs = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
      do_miss({$urandom(), 8'($urandom())} & 40'hFF_FFFF_FFC0, 2'($urandom_range(0, 3)),
              $urandom_range(0, 3), errs, mode, $urandom_range(0, 2), 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

endmodule
